// File: rtl/stack_pop_controller.sv
// Read-side stack sequencer: pops 1/2/3 16-bit words above SP for POP/RET/RTI,
// reassembles PC and flags, and reports the post-pop SP.
module stack_pop_controller #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11,
    parameter int SP_W   = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pop_req,
    input  logic [1:0]        pop_kind,
    input  logic              flush,
    input  logic [SP_W-1:0]   sp_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pop_ready,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic              done,
    output logic              pop_error,
    output logic [DATA_W-1:0] pop_data,
    output logic [PC_W-1:0]   pc_out,
    output logic [2:0]        flags_out,
    output logic [SP_W-1:0]   sp_out
);

    localparam logic [SP_W-1:0] SP_TOP = {{(SP_W-ADDR_W){1'b0}}, {ADDR_W{1'b1}}};
    localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

    localparam logic [1:0] KIND_POP = 2'b00;
    localparam logic [1:0] KIND_RET = 2'b01;
    localparam logic [1:0] KIND_RTI = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_RD2  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          kind_q, kind_d;
    logic [SP_W-1:0]     sp_work_q, sp_work_d;
    logic [DATA_W-1:0]   w0_q, w0_d;
    logic [DATA_W-1:0]   w1_q, w1_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   pop_data_q, pop_data_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [2:0]          flags_q, flags_d;
    logic [SP_W-1:0]     sp_out_q, sp_out_d;
    logic [SP_W-1:0]     n_words_s;
    logic                kind_ok_s;

    // Word count of the requested pop; kind 11 has none and is rejected.
    always_comb begin
        n_words_s = SP_W'(0);
        kind_ok_s = 1'b1;
        case (pop_kind)
            KIND_POP: n_words_s = SP_W'(1);
            KIND_RET: n_words_s = SP_W'(2);
            KIND_RTI: n_words_s = SP_W'(3);
            default:  kind_ok_s = 1'b0;
        endcase
    end

    // Next-state and result computation; flush overrides everything but reset.
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        sp_work_d  = sp_work_q;
        w0_d       = w0_q;
        w1_d       = w1_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        pop_data_d = pop_data_q;
        pc_d       = pc_q;
        flags_d    = flags_q;
        sp_out_d   = sp_out_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop_req) begin
                        // Subtraction form keeps the check free of wrap for any sp_in <= SP_TOP.
                        if (!kind_ok_s || ((SP_TOP - sp_in) < n_words_s)) begin
                            err_d = 1'b1;
                        end else begin
                            kind_d    = pop_kind;
                            sp_work_d = sp_in + SP_ONE;
                            state_d   = S_RD0;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RD0: begin
                    sp_work_d = sp_work_q + SP_ONE;
                    state_d   = (kind_q == KIND_POP) ? S_FIN : S_RD1;
                end
                S_RD1: begin
                    w0_d      = mem_rdata;
                    sp_work_d = sp_work_q + SP_ONE;
                    state_d   = (kind_q == KIND_RTI) ? S_RD2 : S_FIN;
                end
                S_RD2: begin
                    w1_d      = mem_rdata;
                    sp_work_d = sp_work_q + SP_ONE;
                    state_d   = S_FIN;
                end
                S_FIN: begin
                    case (kind_q)
                        KIND_POP: pop_data_d = mem_rdata;
                        KIND_RET: pc_d = {mem_rdata, w0_q};
                        KIND_RTI: begin
                            pc_d    = {mem_rdata, w1_q};
                            flags_d = w0_q[2:0];
                        end
                        default: pop_data_d = pop_data_q;
                    endcase
                    // sp_work has already stepped one past the last word read.
                    sp_out_d = sp_work_q - SP_ONE;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            kind_q     <= 2'b00;
            sp_work_q  <= '0;
            w0_q       <= '0;
            w1_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            pop_data_q <= '0;
            pc_q       <= '0;
            flags_q    <= 3'b000;
            sp_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            sp_work_q  <= sp_work_d;
            w0_q       <= w0_d;
            w1_q       <= w1_d;
            done_q     <= done_d;
            err_q      <= err_d;
            pop_data_q <= pop_data_d;
            pc_q       <= pc_d;
            flags_q    <= flags_d;
            sp_out_q   <= sp_out_d;
        end
    end

    assign pop_ready   = (state_q == S_IDLE);
    assign mem_read_en = (state_q == S_RD0) || (state_q == S_RD1) || (state_q == S_RD2);
    assign mem_address = sp_work_q[ADDR_W-1:0];
    assign done        = done_q;
    assign pop_error   = err_q;
    assign pop_data    = pop_data_q;
    assign pc_out      = pc_q;
    assign flags_out   = flags_q;
    assign sp_out      = sp_out_q;

endmodule

// File: tb/tb_stack_pop_controller.sv
// Bench for stack_pop_controller: directed table, corner sequences, and random ops
// checked against a word-list model of the stack.
module tb_stack_pop_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pop_req = 1'b0;
    logic [1:0]  pop_kind = 2'b00;
    logic        flush = 1'b0;
    logic [31:0] sp_in = 32'd0;
    logic [15:0] mem_rdata = 16'd0;
    logic        pop_ready, mem_read_en, done, pop_error;
    logic [10:0] mem_address;
    logic [15:0] pop_data;
    logic [31:0] pc_out;
    logic [2:0]  flags_out;
    logic [31:0] sp_out;

    logic [15:0] mem [0:2047];

    logic [15:0] m_pop   = 16'd0;
    logic [31:0] m_pc    = 32'd0;
    logic [2:0]  m_flags = 3'd0;
    logic [31:0] m_sp    = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    stack_pop_controller dut (
        .clk(clk), .reset(reset), .pop_req(pop_req), .pop_kind(pop_kind),
        .flush(flush), .sp_in(sp_in), .mem_rdata(mem_rdata),
        .pop_ready(pop_ready), .mem_read_en(mem_read_en), .mem_address(mem_address),
        .done(done), .pop_error(pop_error), .pop_data(pop_data), .pc_out(pc_out),
        .flags_out(flags_out), .sp_out(sp_out)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory; garbage when not reading.
    always @(posedge clk) begin
        if (mem_read_en) mem_rdata <= mem[mem_address];
        else             mem_rdata <= 16'($urandom);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_held(input string tag);
        chk({tag, ".pop_data"}, 64'(pop_data), 64'(m_pop));
        chk({tag, ".pc_out"}, 64'(pc_out), 64'(m_pc));
        chk({tag, ".flags_out"}, 64'(flags_out), 64'(m_flags));
        chk({tag, ".sp_out"}, 64'(sp_out), 64'(m_sp));
    endtask

    // Issue one request now and follow it to completion; the model decides the outcome.
    task automatic run_op(input logic [1:0] k, input logic [31:0] sp);
        int n;
        bit bad;
        logic [15:0] w [3];
        n = int'(k) + 1;
        bad = (k == 2'b11) || ((32'd2047 - sp) < 32'(n));
        for (int i = 0; i < 3; i++)
            w[i] = (sp + 32'(i) + 32'd1 <= 32'd2047) ? mem[sp + 32'(i) + 32'd1] : 16'd0;
        chk("ready_at_issue", 64'(pop_ready), 64'd1);
        pop_req = 1'b1; pop_kind = k; sp_in = sp;
        step();
        pop_req = 1'b0; pop_kind = 2'($urandom); sp_in = $urandom;
        if (bad) begin
            chk("err_pulse", 64'(pop_error), 64'd1);
            chk("err_no_read", 64'(mem_read_en), 64'd0);
            chk("err_ready", 64'(pop_ready), 64'd1);
            step();
            chk("err_pulse_end", 64'(pop_error), 64'd0);
            chk("err_no_done", 64'(done), 64'd0);
            chk("err_no_read2", 64'(mem_read_en), 64'd0);
            chk_held("err_held");
        end else begin
            for (int c = 1; c <= n; c++) begin
                chk("rd_en", 64'(mem_read_en), 64'd1);
                chk("rd_addr", 64'(mem_address), 64'((sp + 32'(c)) & 32'h7FF));
                chk("busy_not_ready", 64'(pop_ready), 64'd0);
                step();
            end
            chk("fin_no_read", 64'(mem_read_en), 64'd0);
            chk("fin_no_done", 64'(done), 64'd0);
            step();
            case (k)
                2'b00: m_pop = w[0];
                2'b01: m_pc = {w[1], w[0]};
                default: begin
                    m_flags = w[0][2:0];
                    m_pc = {w[2], w[1]};
                end
            endcase
            m_sp = sp + 32'(n);
            chk("done", 64'(done), 64'd1);
            chk("done_no_err", 64'(pop_error), 64'd0);
            chk_held("result");
        end
    endtask

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] sp;
        logic [15:0] m0, m1, m2;
        logic [15:0] e_pop;
        logic [31:0] e_pc;
        logic [2:0]  e_flags;
        logic [31:0] e_sp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{2'b00, 32'd2045, 16'hBEEF, 16'h0, 16'h0, 16'hBEEF, 32'h0, 3'd0, 32'd2046};
        vecs[1] = '{2'b01, 32'd2044, 16'h5678, 16'h1234, 16'h0, 16'hBEEF, 32'h12345678, 3'd0, 32'd2046};
        vecs[2] = '{2'b10, 32'd2043, 16'h0005, 16'h0020, 16'h0000, 16'hBEEF, 32'h20, 3'd5, 32'd2046};
        vecs[3] = '{2'b00, 32'd2047, 16'h0, 16'h0, 16'h0, 16'hBEEF, 32'h20, 3'd5, 32'd2046};
        vecs[4] = '{2'b01, 32'd2046, 16'h0, 16'h0, 16'h0, 16'hBEEF, 32'h20, 3'd5, 32'd2046};
        vecs[5] = '{2'b11, 32'd2000, 16'h0, 16'h0, 16'h0, 16'hBEEF, 32'h20, 3'd5, 32'd2046};
        vecs[6] = '{2'b10, 32'd2044, 16'hFFFA, 16'hCAFE, 16'hABCD, 16'hBEEF, 32'hABCDCAFE, 3'd2, 32'd2047};
        vecs[7] = '{2'b00, 32'd2040, 16'h0001, 16'h0, 16'h0, 16'h0001, 32'hABCDCAFE, 3'd2, 32'd2041};

        for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);

        #2;
        chk("reset_rd_en", 64'(mem_read_en), 64'd0);
        chk("reset_ready", 64'(pop_ready), 64'd1);
        #10 reset = 1'b0;
        step();
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_err", 64'(pop_error), 64'd0);
        chk_held("reset");

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].sp + 32'd1 <= 32'd2047) mem[vecs[i].sp + 32'd1] = vecs[i].m0;
            if (vecs[i].sp + 32'd2 <= 32'd2047) mem[vecs[i].sp + 32'd2] = vecs[i].m1;
            if (vecs[i].sp + 32'd3 <= 32'd2047) mem[vecs[i].sp + 32'd3] = vecs[i].m2;
            run_op(vecs[i].kind, vecs[i].sp);
            chk("vec_pop_data", 64'(pop_data), 64'(vecs[i].e_pop));
            chk("vec_pc_out", 64'(pc_out), 64'(vecs[i].e_pc));
            chk("vec_flags", 64'(flags_out), 64'(vecs[i].e_flags));
            chk("vec_sp_out", 64'(sp_out), 64'(vecs[i].e_sp));
            step();
            chk("done_one_cycle", 64'(done), 64'd0);
        end

        // Back-to-back: second request issued in the done cycle of the first.
        run_op(2'b00, 32'd2030);
        run_op(2'b01, sp_out);
        chk("b2b_sp_out", 64'(sp_out), 64'd2033);
        step();

        // Flush in RD1 of a RET: no done, results untouched.
        pop_req = 1'b1; pop_kind = 2'b01; sp_in = 32'd2040;
        step();
        pop_req = 1'b0;
        chk("fl_rd0", 64'(mem_read_en), 64'd1);
        step();
        chk("fl_rd1_addr", 64'(mem_address), 64'd2042);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_idle", 64'(pop_ready), 64'd1);
        chk("fl_no_read", 64'(mem_read_en), 64'd0);
        chk("fl_no_done", 64'(done), 64'd0);
        step();
        chk("fl_no_done2", 64'(done), 64'd0);
        chk_held("flush");

        // Flush in IDLE blocks acceptance, including of an illegal request.
        pop_req = 1'b1; pop_kind = 2'b00; sp_in = 32'd2040; flush = 1'b1;
        step();
        chk("fli_no_read", 64'(mem_read_en), 64'd0);
        chk("fli_ready", 64'(pop_ready), 64'd1);
        pop_kind = 2'b11;
        step();
        pop_req = 1'b0; flush = 1'b0;
        chk("fli_no_err", 64'(pop_error), 64'd0);
        step();
        chk("fli_no_done", 64'(done), 64'd0);

        // Async reset during RD0 of an RTI.
        pop_req = 1'b1; pop_kind = 2'b10; sp_in = 32'd2040;
        step();
        pop_req = 1'b0;
        chk("rst_rd0", 64'(mem_read_en), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_rd_en_now", 64'(mem_read_en), 64'd0);
        chk("rst_ready_now", 64'(pop_ready), 64'd1);
        m_pop = 16'd0; m_pc = 32'd0; m_flags = 3'd0; m_sp = 32'd0;
        chk_held("rst_mid");
        #2 reset = 1'b0;
        step();
        chk("rst_rel_ready", 64'(pop_ready), 64'd1);
        chk("rst_rel_no_read", 64'(mem_read_en), 64'd0);
        step();
        chk("rst_rel_no_done", 64'(done), 64'd0);

        // Random ops against the model.
        for (int it = 0; it < 60; it++) begin
            int gap;
            for (int a = 2030; a < 2048; a++) mem[a] = 16'($urandom);
            run_op(2'($urandom_range(0, 3)), 32'($urandom_range(2030, 2047)));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                step();
                chk("gap_no_done", 64'(done), 64'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
